tap_loader: RTL



---
 rtl/tap_pkg.sv | 27 ++
 rtl/tap_header_parser.sv | 44 ++++
 rtl/tap_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tap_pkg.sv
// tap_pkg: state encoding, framing bytes and header field offsets shared by
// the Oric TAP loader and its header parser.
package tap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_NAME,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } tap_state_e;

  localparam logic [7:0]  TAP_SYNC_BYTE  = 8'h16;
  localparam logic [7:0]  TAP_START_BYTE = 8'h24;
  localparam int unsigned TAP_HDR_LEN    = 9;

  localparam logic [3:0] HDR_IDX_TYPE     = 4'd2;
  localparam logic [3:0] HDR_IDX_AUTORUN  = 4'd3;
  localparam logic [3:0] HDR_IDX_END_HI   = 4'd4;
  localparam logic [3:0] HDR_IDX_END_LO   = 4'd5;
  localparam logic [3:0] HDR_IDX_START_HI = 4'd6;
  localparam logic [3:0] HDR_IDX_START_LO = 4'd7;
  localparam logic [3:0] HDR_IDX_LAST     = 4'(TAP_HDR_LEN - 1);

endpackage

// File: rtl/tap_header_parser.sv
// tap_header_parser: captures the fields of the 9-byte TAP header and flags
// the final header byte plus an inverted (end < start) address range.
module tap_header_parser
  import tap_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic [3:0]  byte_idx,
  output logic [7:0]  hdr_type,
  output logic        hdr_autorun,
  output logic [15:0] hdr_start,
  output logic [15:0] hdr_end,
  output logic        hdr_valid,
  output logic        hdr_bad
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hdr_type    <= 8'h00;
      hdr_autorun <= 1'b0;
      hdr_start   <= 16'h0000;
      hdr_end     <= 16'h0000;
    end else if (byte_valid) begin
      case (byte_idx)
        HDR_IDX_TYPE:     hdr_type          <= byte_in;
        HDR_IDX_AUTORUN:  hdr_autorun       <= (byte_in != 8'h00);
        HDR_IDX_END_HI:   hdr_end[15:8]     <= byte_in;
        HDR_IDX_END_LO:   hdr_end[7:0]      <= byte_in;
        HDR_IDX_START_HI: hdr_start[15:8]   <= byte_in;
        HDR_IDX_START_LO: hdr_start[7:0]    <= byte_in;
        default: ;
      endcase
    end
  end

  // Byte 8 carries no field, so start/end are already registered when it arrives.
  assign hdr_valid = byte_valid && (byte_idx == HDR_IDX_LAST);
  assign hdr_bad   = (hdr_end < hdr_start);

endmodule

// File: rtl/tap_loader.sv
// tap_loader: parses Oric TAP blocks from the ioctl download stream and writes
// program data to RAM. Define TAP_MULTIBLOCK_EN to load every block in an image.
module tap_loader
  import tap_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_NAME = 16,
  parameter int unsigned MIN_SYNC = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              mem_ready,
  output logic              tape_wr,
  output logic [ADDR_W-1:0] tape_addr,
  output logic [7:0]        tape_dout,
  output logic [15:0]       loadpoint,
  output logic [15:0]       execpoint,
  output logic              autostart,
  output logic [7:0]        block_count,
  output logic              tape_complete,
  output logic              tape_error,
  output logic              tape_autorun
);

  localparam int unsigned NAME_W = $clog2(MAX_NAME + 1);

  tap_state_e        state_q, state_d;
  logic              dl_q, end_req_q, last_pend_q, exec_set_q, arm_q;
  logic [7:0]        sync_cnt_q;
  logic [3:0]        hdr_idx_q;
  logic [NAME_W-1:0] name_cnt_q;
  logic [15:0]       data_addr_q;

  logic [7:0]  unused_hdr_type;
  logic        hdr_autorun, hdr_valid, hdr_bad;
  logic [15:0] hdr_start, hdr_end;

  logic dl_rise, dl_fall, consume, byte_take, end_go, complete_go;
  logic sync_take, hdr_take, name_take, data_take, data_last;

  assign ioctl_wait  = tape_wr & ~mem_ready;
  assign consume     = ioctl_wr & ~ioctl_wait;
  assign dl_rise     = ioctl_download & ~dl_q;
  assign dl_fall     = ~ioctl_download & dl_q;
  // The end-of-download verdict waits until the block's final write has landed.
  assign end_go      = end_req_q & ~last_pend_q & ~dl_rise;
  assign complete_go = end_go && (state_q == ST_DONE ||
                                  (state_q == ST_SYNC && block_count != 8'd0));
  assign byte_take   = consume & ~dl_rise & ~end_go;
  assign sync_take   = byte_take && (state_q == ST_SYNC);
  assign hdr_take    = byte_take && (state_q == ST_HDR);
  assign name_take   = byte_take && (state_q == ST_NAME);
  assign data_take   = byte_take && (state_q == ST_DATA);
  assign data_last   = data_take && (data_addr_q == hdr_end);

  tap_header_parser u_hdr (
    .clk         (clk),
    .reset_n     (reset_n),
    .byte_valid  (hdr_take),
    .byte_in     (ioctl_dout),
    .byte_idx    (hdr_idx_q),
    .hdr_type    (unused_hdr_type),
    .hdr_autorun (hdr_autorun),
    .hdr_start   (hdr_start),
    .hdr_end     (hdr_end),
    .hdr_valid   (hdr_valid),
    .hdr_bad     (hdr_bad)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d is defaulted before any branch so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (dl_rise) begin
      state_d = ST_SYNC;
    end else if (end_go) begin
      case (state_q)
        ST_SYNC:                  state_d = (block_count != 8'd0) ? ST_DONE : ST_ERR;
        ST_HDR, ST_NAME, ST_DATA: state_d = ST_ERR;
        default: ;
      endcase
    end else if (byte_take) begin
      case (state_q)
        ST_SYNC:
          if (ioctl_dout == TAP_START_BYTE && sync_cnt_q >= 8'(MIN_SYNC)) state_d = ST_HDR;
        ST_HDR:
          if (hdr_valid) state_d = hdr_bad ? ST_ERR : ST_NAME;
        ST_NAME:
          if (ioctl_dout == 8'h00)                  state_d = ST_DATA;
          else if (name_cnt_q == NAME_W'(MAX_NAME)) state_d = ST_ERR;
        ST_DATA:
          if (data_last) begin
`ifdef TAP_MULTIBLOCK_EN
            state_d = ST_SYNC;
`else
            state_d = ST_DONE;
`endif
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dl_q          <= 1'b0;
      end_req_q     <= 1'b0;
      last_pend_q   <= 1'b0;
      exec_set_q    <= 1'b0;
      arm_q         <= 1'b0;
      sync_cnt_q    <= 8'd0;
      hdr_idx_q     <= 4'd0;
      name_cnt_q    <= '0;
      data_addr_q   <= 16'h0000;
      tape_wr       <= 1'b0;
      tape_addr     <= '0;
      tape_dout     <= 8'h00;
      loadpoint     <= 16'h0000;
      execpoint     <= 16'h0000;
      autostart     <= 1'b0;
      block_count   <= 8'd0;
      tape_complete <= 1'b0;
      tape_error    <= 1'b0;
      tape_autorun  <= 1'b0;
    end else begin
      dl_q         <= ioctl_download;
      arm_q        <= 1'b0;
      tape_autorun <= arm_q;

      if (sync_take) begin
        if (ioctl_dout == TAP_SYNC_BYTE) begin
          if (sync_cnt_q != 8'hFF) sync_cnt_q <= sync_cnt_q + 8'd1;
        end else begin
          sync_cnt_q <= 8'd0;
        end
      end

      if (state_q != ST_HDR) hdr_idx_q <= 4'd0;
      else if (hdr_take)     hdr_idx_q <= hdr_idx_q + 4'd1;

      if (state_q != ST_NAME) name_cnt_q <= '0;
      else if (name_take && ioctl_dout != 8'h00 && name_cnt_q != NAME_W'(MAX_NAME))
        name_cnt_q <= name_cnt_q + NAME_W'(1);

      if (hdr_valid && hdr_take) data_addr_q <= hdr_start;

      if (tape_wr && mem_ready) begin
        tape_wr <= 1'b0;
        if (last_pend_q) begin
          last_pend_q <= 1'b0;
          loadpoint   <= hdr_start;
          if (block_count != 8'hFF) block_count <= block_count + 8'd1;
          if (hdr_autorun) begin
            autostart  <= 1'b1;
            exec_set_q <= 1'b1;
          end
          if (!exec_set_q && (hdr_autorun || block_count == 8'd0)) execpoint <= hdr_start;
        end
      end

      // A new byte may be accepted on the same edge the previous write retires.
      if (data_take) begin
        tape_wr     <= 1'b1;
        tape_addr   <= ADDR_W'(data_addr_q);
        tape_dout   <= ioctl_dout;
        data_addr_q <= data_addr_q + 16'd1;
        if (data_last) last_pend_q <= 1'b1;
      end

      if (end_go) begin
        end_req_q <= 1'b0;
        if (complete_go) begin
          tape_complete <= 1'b1;
          arm_q         <= autostart;
        end
      end
      if (dl_fall) end_req_q <= 1'b1;

      if (state_d == ST_ERR && state_q != ST_ERR) tape_error <= 1'b1;

      if (dl_rise) begin
        end_req_q     <= 1'b0;
        last_pend_q   <= 1'b0;
        exec_set_q    <= 1'b0;
        arm_q         <= 1'b0;
        sync_cnt_q    <= 8'd0;
        tape_wr       <= 1'b0;
        tape_addr     <= '0;
        tape_dout     <= 8'h00;
        autostart     <= 1'b0;
        block_count   <= 8'd0;
        tape_complete <= 1'b0;
        tape_error    <= 1'b0;
        tape_autorun  <= 1'b0;
      end
    end
  end

endmodule
